// File: rtl/cl_pcim_result_writer.sv
// PCIM result writer: drains the 512b result stream into host memory as
// fixed-length AXI4 INCR bursts from a programmed base address, one burst
// outstanding at a time.
module cl_pcim_result_writer #(
  parameter int unsigned DATA_W    = 512,
  parameter int unsigned ADDR_W    = 64,
  parameter int unsigned ID_W      = 16,
  parameter int unsigned AWID      = 0,
  parameter int unsigned BURST_LEN = 64
) (
  input  logic                  clock,
  input  logic                  reset,

  input  logic [ADDR_W-1:0]     cfg_base_addr,
  input  logic [15:0]           cfg_num_bursts,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [15:0]           bursts_done,

  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [DATA_W-1:0]     s_axis_tdata,

  output logic [ID_W-1:0]       m_axi_awid,
  output logic [ADDR_W-1:0]     m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,

  output logic [DATA_W-1:0]     m_axi_wdata,
  output logic [DATA_W/8-1:0]   m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,

  input  logic [ID_W-1:0]       m_axi_bid,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready
);

  localparam int unsigned StrbW      = DATA_W / 8;
  localparam int unsigned BeatW      = $clog2(BURST_LEN);
  // Byte span of one burst; bursts are laid out back to back from the base.
  localparam int unsigned BurstShift = $clog2(BURST_LEN * StrbW);
  localparam logic [1:0]  RespOkay   = 2'b00;

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StAddr,
    StData,
    StResp,
    StDone
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [15:0]         num_q, num_d;
  logic [15:0]         burst_idx_q, burst_idx_d;
  logic [BeatW-1:0]    beat_q, beat_d;
  logic                err_q, err_d;

  logic                w_hs;
  logic                last_beat;

  // Single ID and one burst in flight, so the response ID carries no information.
  logic                unused_bid;
  assign unused_bid = ^m_axi_bid;

  assign last_beat = (beat_q == BeatW'(BURST_LEN - 1));
  assign w_hs      = m_axi_wvalid && m_axi_wready;

  // Next-state logic: job sequencing, burst/beat counters and sticky error.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    num_d       = num_q;
    burst_idx_d = burst_idx_q;
    beat_d      = beat_q;
    err_d       = err_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          base_d      = cfg_base_addr;
          num_d       = cfg_num_bursts;
          burst_idx_d = '0;
          beat_d      = '0;
          err_d       = 1'b0;
          state_d     = StCheck;
        end
      end
      StCheck: begin
        if (base_q[BurstShift-1:0] != '0) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else if (num_q == 16'd0) begin
          state_d = StDone;
        end else begin
          state_d = StAddr;
        end
      end
      StAddr: begin
        if (m_axi_awready) begin
          state_d = StData;
        end
      end
      StData: begin
        if (w_hs) begin
          if (last_beat) begin
            beat_d  = '0;
            state_d = StResp;
          end else begin
            beat_d = beat_q + BeatW'(1);
          end
        end
      end
      StResp: begin
        if (m_axi_bvalid) begin
          if (m_axi_bresp == RespOkay) begin
            burst_idx_d = burst_idx_q + 16'd1;
            state_d     = (burst_idx_d == num_q) ? StDone : StAddr;
          end else begin
            err_d   = 1'b1;
            state_d = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State register with synchronous reset; an in-flight burst is simply dropped.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      base_q      <= '0;
      num_q       <= '0;
      burst_idx_q <= '0;
      beat_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      num_q       <= num_d;
      burst_idx_q <= burst_idx_d;
      beat_q      <= beat_d;
      err_q       <= err_d;
    end
  end

  // Status outputs.
  assign busy        = (state_q == StCheck) || (state_q == StAddr) ||
                       (state_q == StData)  || (state_q == StResp);
  assign done        = (state_q == StDone);
  assign err         = err_q;
  assign bursts_done = burst_idx_q;

  // Write address channel: address derives only from registers, so it is stable while waiting.
  assign m_axi_awid    = ID_W'(AWID);
  assign m_axi_awaddr  = base_q + (ADDR_W'(burst_idx_q) << BurstShift);
  assign m_axi_awlen   = 8'(BURST_LEN - 1);
  assign m_axi_awsize  = 3'($clog2(StrbW));
  assign m_axi_awvalid = (state_q == StAddr);

  // Write data channel is a straight pass-through of the stream, gated to the data phase.
  assign m_axi_wvalid  = (state_q == StData) && s_axis_tvalid;
  assign s_axis_tready = (state_q == StData) && m_axi_wready;
  assign m_axi_wdata   = s_axis_tdata;
  assign m_axi_wstrb   = {StrbW{1'b1}};
  assign m_axi_wlast   = (state_q == StData) && last_beat;

  assign m_axi_bready  = (state_q == StResp);

endmodule

// File: tb/tb_cl_pcim_result_writer.sv
// Bench for cl_pcim_result_writer: random stream/ready/response agents, a
// negedge bus monitor, and per-scenario tasks checking against expected queues.
module tb_cl_pcim_result_writer;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [63:0]  cfg_base_addr = '0;
  logic [15:0]  cfg_num_bursts = '0;
  logic         start = 1'b0;
  logic         busy, done, err;
  logic [15:0]  bursts_done;
  logic         s_axis_tvalid = 1'b0;
  logic         s_axis_tready;
  logic [511:0] s_axis_tdata = '0;
  logic [15:0]  m_axi_awid;
  logic [63:0]  m_axi_awaddr;
  logic [7:0]   m_axi_awlen;
  logic [2:0]   m_axi_awsize;
  logic         m_axi_awvalid;
  logic         m_axi_awready = 1'b0;
  logic [511:0] m_axi_wdata;
  logic [63:0]  m_axi_wstrb;
  logic         m_axi_wlast;
  logic         m_axi_wvalid;
  logic         m_axi_wready = 1'b0;
  logic [15:0]  m_axi_bid = '0;
  logic [1:0]   m_axi_bresp = 2'b00;
  logic         m_axi_bvalid = 1'b0;
  logic         m_axi_bready;

  cl_pcim_result_writer dut (
    .clock          (clock),
    .reset          (reset),
    .cfg_base_addr  (cfg_base_addr),
    .cfg_num_bursts (cfg_num_bursts),
    .start          (start),
    .busy           (busy),
    .done           (done),
    .err            (err),
    .bursts_done    (bursts_done),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tready  (s_axis_tready),
    .s_axis_tdata   (s_axis_tdata),
    .m_axi_awid     (m_axi_awid),
    .m_axi_awaddr   (m_axi_awaddr),
    .m_axi_awlen    (m_axi_awlen),
    .m_axi_awsize   (m_axi_awsize),
    .m_axi_awvalid  (m_axi_awvalid),
    .m_axi_awready  (m_axi_awready),
    .m_axi_wdata    (m_axi_wdata),
    .m_axi_wstrb    (m_axi_wstrb),
    .m_axi_wlast    (m_axi_wlast),
    .m_axi_wvalid   (m_axi_wvalid),
    .m_axi_wready   (m_axi_wready),
    .m_axi_bid      (m_axi_bid),
    .m_axi_bresp    (m_axi_bresp),
    .m_axi_bvalid   (m_axi_bvalid),
    .m_axi_bready   (m_axi_bready)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Stimulus knobs and stream contents, written by the main sequence only.
  logic [511:0] stream_data [0:2047];
  int           stream_total = 0;
  bit           flush = 1'b0;
  int           gap_pct = 0;
  int           w_stall_pct = 0;
  int           aw_stall_pct = 0;
  int           slverr_at = -1;
  logic [63:0]  exp_aw [$];

  // Monitor state, written by the monitor only.
  int           n_aw = 0, n_w = 0, n_wlast = 0, n_done = 0;
  int           proto_err = 0, attr_err = 0;
  logic [63:0]  obs_aw [0:255];
  logic [511:0] obs_w  [0:2047];
  logic         obs_wl [0:2047];
  bit           s_hs = 1'b0, b_hs = 1'b0;
  bit           aw_open = 1'b0, aw_stall = 1'b0, w_stall = 1'b0;
  logic [63:0]  aw_prev = '0;

  int           s_idx = 0;
  int           b_sent = 0;

  // Bus monitor, sampling mid-cycle; a handshake seen here completes on the next posedge.
  always @(negedge clock) begin
    s_hs = s_axis_tvalid && s_axis_tready;
    b_hs = m_axi_bvalid && m_axi_bready;
    if (reset) begin
      aw_open  = 1'b0;
      aw_stall = 1'b0;
      w_stall  = 1'b0;
    end else begin
      if (aw_stall && (!m_axi_awvalid || m_axi_awaddr !== aw_prev)) proto_err++;
      if (w_stall && !m_axi_wvalid) proto_err++;
      if (m_axi_awvalid && m_axi_awready) begin
        if (m_axi_awlen !== 8'd63 || m_axi_awsize !== 3'd6 || m_axi_awid !== 16'd0) attr_err++;
        obs_aw[n_aw] = m_axi_awaddr;
        n_aw++;
        aw_open = 1'b1;
      end
      if (m_axi_wvalid && m_axi_wready) begin
        if (!aw_open || m_axi_wstrb !== {64{1'b1}}) proto_err++;
        obs_w[n_w]  = m_axi_wdata;
        obs_wl[n_w] = m_axi_wlast;
        n_w++;
        if (m_axi_wlast) begin
          n_wlast++;
          aw_open = 1'b0;
        end
      end
      if (done) n_done++;
      aw_stall = m_axi_awvalid && !m_axi_awready;
      aw_prev  = m_axi_awaddr;
      w_stall  = m_axi_wvalid && !m_axi_wready;
    end
  end

  // AXIS source: holds a beat until accepted, random gaps between beats.
  always begin
    @(posedge clock);
    #1;
    if (flush) begin
      s_axis_tvalid = 1'b0;
      s_idx = stream_total;
    end else begin
      if (s_axis_tvalid && s_hs) s_axis_tvalid = 1'b0;
      if (!s_axis_tvalid && s_idx < stream_total && $urandom_range(99) >= gap_pct) begin
        s_axis_tdata  = stream_data[s_idx];
        s_idx++;
        s_axis_tvalid = 1'b1;
      end
    end
  end

  // Slave-side ready generators.
  always begin
    @(posedge clock);
    #1;
    m_axi_awready = ($urandom_range(99) >= aw_stall_pct);
    m_axi_wready  = ($urandom_range(99) >= w_stall_pct);
  end

  // Write response agent: one response per completed W burst, SLVERR on a chosen one.
  always begin
    @(posedge clock);
    #1;
    if (reset) begin
      m_axi_bvalid = 1'b0;
    end else begin
      if (m_axi_bvalid && b_hs) begin
        m_axi_bvalid = 1'b0;
        b_sent++;
      end
      if (!m_axi_bvalid && b_sent < n_wlast) begin
        m_axi_bvalid = 1'b1;
        m_axi_bresp  = (b_sent == slverr_at) ? 2'b10 : 2'b00;
      end
    end
  end

  task automatic push_stream(input int n);
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 16; k++) stream_data[stream_total][k*32 +: 32] = $urandom();
      stream_total++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic pulse_start(input logic [63:0] base, input logic [15:0] num);
    cfg_base_addr  = base;
    cfg_num_bursts = num;
    start          = 1'b1;
    @(posedge clock);
    #1;
    start          = 1'b0;
  endtask

  // Leaves the caller at the negedge where done is high, or flags a timeout.
  task automatic wait_done(output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clock);
      if (done === 1'b1) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  // Beats that differ from the stream (data or expected wlast position).
  function automatic int count_bad(input int w0, input int s0, input int n);
    int bad = 0;
    for (int j = 0; j < n; j++) begin
      if (obs_w[w0+j] !== stream_data[s0+j] || obs_wl[w0+j] !== ((j % 64) == 63)) bad++;
    end
    return bad;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    idle(3);
    @(negedge clock);
    n_tests++;
    if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready, busy, done, err, s_axis_tready} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: aw/w/b/busy/done/err/tready=%b want 0000000",
               {m_axi_awvalid, m_axi_wvalid, m_axi_bready, busy, done, err, s_axis_tready});
    end
    n_tests++;
    if (bursts_done !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_bursts_done: got %0d want 0", bursts_done);
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    idle(2);
  endtask

  task automatic test_single_burst();
    int aw0, w0, s0, bad;
    bit to;
    logic [63:0] e;
    gap_pct = 0; w_stall_pct = 0; aw_stall_pct = 0;
    aw0 = n_aw; w0 = n_w; s0 = stream_total;
    push_stream(64);
    exp_aw.push_back(64'h1000_0000);
    pulse_start(64'h1000_0000, 16'd1);
    wait_done(to);
    n_tests++;
    if (to !== 1'b0) begin n_fail++; $display("FAIL t1_done: timeout=%0d want 0", to); end
    n_tests++;
    if (err !== 1'b0 || bursts_done !== 16'd1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL t1_status: err=%0d bursts=%0d busy=%0d want 0 1 0", err, bursts_done, busy);
    end
    @(negedge clock);
    n_tests++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL t1_done_pulse: done=%0d want 0", done); end
    @(posedge clock);
    #1;
    n_tests++;
    if (n_aw - aw0 !== 1) begin n_fail++; $display("FAIL t1_aw_count: got %0d want 1", n_aw - aw0); end
    for (int k = 0; exp_aw.size() > 0; k++) begin
      e = exp_aw.pop_front();
      n_tests++;
      if (obs_aw[aw0+k] !== e) begin
        n_fail++;
        $display("FAIL t1_awaddr: got %h want %h", obs_aw[aw0+k], e);
      end
    end
    n_tests++;
    if (n_w - w0 !== 64) begin n_fail++; $display("FAIL t1_w_count: got %0d want 64", n_w - w0); end
    bad = count_bad(w0, s0, 64);
    n_tests++;
    if (bad !== 0) begin n_fail++; $display("FAIL t1_wdata_wlast: bad beats %0d want 0", bad); end
    n_tests++;
    if (attr_err !== 0 || proto_err !== 0) begin
      n_fail++;
      $display("FAIL t1_protocol: attr_err=%0d proto_err=%0d want 0 0", attr_err, proto_err);
    end
  endtask

  task automatic test_multi_burst_stalls();
    int aw0, w0, s0, bad;
    bit to;
    logic [63:0] e;
    gap_pct = 30; w_stall_pct = 30; aw_stall_pct = 40;
    aw0 = n_aw; w0 = n_w; s0 = stream_total;
    push_stream(192);
    for (int k = 0; k < 3; k++) exp_aw.push_back(64'h2000_0000 + 64'(k) * 64'h1000);
    pulse_start(64'h2000_0000, 16'd3);
    wait_done(to);
    n_tests++;
    if (to !== 1'b0) begin n_fail++; $display("FAIL t2_done: timeout=%0d want 0", to); end
    n_tests++;
    if (err !== 1'b0 || bursts_done !== 16'd3) begin
      n_fail++;
      $display("FAIL t2_status: err=%0d bursts=%0d want 0 3", err, bursts_done);
    end
    @(posedge clock);
    #1;
    n_tests++;
    if (n_aw - aw0 !== 3) begin n_fail++; $display("FAIL t2_aw_count: got %0d want 3", n_aw - aw0); end
    for (int k = 0; exp_aw.size() > 0; k++) begin
      e = exp_aw.pop_front();
      n_tests++;
      if (obs_aw[aw0+k] !== e) begin
        n_fail++;
        $display("FAIL t2_awaddr%0d: got %h want %h", k, obs_aw[aw0+k], e);
      end
    end
    bad = count_bad(w0, s0, 192);
    n_tests++;
    if (n_w - w0 !== 192 || bad !== 0) begin
      n_fail++;
      $display("FAIL t2_wdata: beats %0d bad %0d want 192 0", n_w - w0, bad);
    end
    n_tests++;
    if (attr_err !== 0 || proto_err !== 0) begin
      n_fail++;
      $display("FAIL t2_protocol: attr_err=%0d proto_err=%0d want 0 0", attr_err, proto_err);
    end
    gap_pct = 0; w_stall_pct = 0; aw_stall_pct = 0;
  endtask

  task automatic test_slverr();
    int aw0, w0, s0, bad;
    bit to;
    aw0 = n_aw; w0 = n_w; s0 = stream_total;
    slverr_at = n_wlast + 1;
    push_stream(128);
    pulse_start(64'h3000_0000, 16'd4);
    wait_done(to);
    n_tests++;
    if (to !== 1'b0) begin n_fail++; $display("FAIL t3_done: timeout=%0d want 0", to); end
    n_tests++;
    if (err !== 1'b1 || bursts_done !== 16'd1) begin
      n_fail++;
      $display("FAIL t3_status: err=%0d bursts=%0d want 1 1", err, bursts_done);
    end
    idle(20);
    slverr_at = -1;
    n_tests++;
    if (n_aw - aw0 !== 2 || n_w - w0 !== 128) begin
      n_fail++;
      $display("FAIL t3_abort: aw %0d w %0d want 2 128", n_aw - aw0, n_w - w0);
    end
    n_tests++;
    if (obs_aw[aw0+1] !== 64'h3000_1000) begin
      n_fail++;
      $display("FAIL t3_awaddr: got %h want 3000_1000", obs_aw[aw0+1]);
    end
    bad = count_bad(w0, s0, 128);
    n_tests++;
    if (bad !== 0) begin n_fail++; $display("FAIL t3_wdata: bad beats %0d want 0", bad); end
    n_tests++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL t3_err_sticky: err=%0d want 1", err); end
  endtask

  task automatic test_bad_cfg();
    int aw0, w0;
    bit to;
    aw0 = n_aw; w0 = n_w;
    pulse_start(64'h1000_0040, 16'd2);
    @(negedge clock);
    n_tests++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL t4_check_cycle: busy=%0d done=%0d want 1 0", busy, done);
    end
    @(negedge clock);
    n_tests++;
    if (done !== 1'b1 || err !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL t4_misaligned: done=%0d err=%0d busy=%0d want 1 1 0", done, err, busy);
    end
    idle(6);
    n_tests++;
    if (n_aw !== aw0 || n_w !== w0) begin
      n_fail++;
      $display("FAIL t4_no_traffic: aw %0d w %0d want 0 0", n_aw - aw0, n_w - w0);
    end
    pulse_start(64'h1000_0000, 16'd0);
    wait_done(to);
    n_tests++;
    if (to !== 1'b0 || err !== 1'b0 || bursts_done !== 16'd0) begin
      n_fail++;
      $display("FAIL t4_zero: timeout=%0d err=%0d bursts=%0d want 0 0 0", to, err, bursts_done);
    end
    idle(4);
    n_tests++;
    if (n_aw !== aw0 || n_w !== w0) begin
      n_fail++;
      $display("FAIL t4_zero_traffic: aw %0d w %0d want 0 0", n_aw - aw0, n_w - w0);
    end
  endtask

  task automatic test_start_while_busy();
    int aw0, w0, s0, d0, bad;
    bit to;
    logic [63:0] e;
    pulse_start(64'h0000_0100, 16'd1);
    wait_done(to);
    @(posedge clock);
    #1;
    n_tests++;
    if (to !== 1'b0 || err !== 1'b1) begin
      n_fail++;
      $display("FAIL t5_seed_err: timeout=%0d err=%0d want 0 1", to, err);
    end
    w_stall_pct = 20; gap_pct = 20;
    aw0 = n_aw; w0 = n_w; s0 = stream_total; d0 = n_done;
    push_stream(64);
    exp_aw.push_back(64'h4000_0000);
    pulse_start(64'h4000_0000, 16'd1);
    @(negedge clock);
    n_tests++;
    if (err !== 1'b0 || busy !== 1'b1 || bursts_done !== 16'd0) begin
      n_fail++;
      $display("FAIL t5_start_clears: err=%0d busy=%0d bursts=%0d want 0 1 0", err, busy, bursts_done);
    end
    @(posedge clock);
    #1;
    idle(10);
    n_tests++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL t5_busy: busy=%0d want 1", busy); end
    pulse_start(64'h5000_0000, 16'd3);
    wait_done(to);
    n_tests++;
    if (to !== 1'b0 || err !== 1'b0 || bursts_done !== 16'd1) begin
      n_fail++;
      $display("FAIL t5_status: timeout=%0d err=%0d bursts=%0d want 0 0 1", to, err, bursts_done);
    end
    idle(12);
    n_tests++;
    if (n_aw - aw0 !== 1 || n_done - d0 !== 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL t5_ignored: aw %0d dones %0d busy %0d want 1 1 0", n_aw - aw0, n_done - d0, busy);
    end
    for (int k = 0; exp_aw.size() > 0; k++) begin
      e = exp_aw.pop_front();
      n_tests++;
      if (obs_aw[aw0+k] !== e) begin
        n_fail++;
        $display("FAIL t5_awaddr: got %h want %h", obs_aw[aw0+k], e);
      end
    end
    bad = count_bad(w0, s0, 64);
    n_tests++;
    if (n_w - w0 !== 64 || bad !== 0) begin
      n_fail++;
      $display("FAIL t5_wdata: beats %0d bad %0d want 64 0", n_w - w0, bad);
    end
    w_stall_pct = 0; gap_pct = 0;
  endtask

  task automatic test_reset_mid_data();
    int aw0, w0, s0, bad;
    bit to;
    bit reached;
    logic [63:0] e;
    w0 = n_w;
    push_stream(128);
    pulse_start(64'h6000_0000, 16'd2);
    reached = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clock);
      if (n_w - w0 >= 20) begin
        reached = 1'b1;
        break;
      end
    end
    n_tests++;
    if (reached !== 1'b1) begin n_fail++; $display("FAIL t6_reach_beat20: beats %0d want 20", n_w - w0); end
    @(posedge clock);
    #1;
    reset = 1'b1;
    flush = 1'b1;
    @(posedge clock);
    @(negedge clock);
    n_tests++;
    if ({m_axi_awvalid, m_axi_wvalid, s_axis_tready, busy, m_axi_bready, done, err} !== 7'b0 ||
        bursts_done !== 16'd0) begin
      n_fail++;
      $display("FAIL t6_reset_outputs: aw/w/tready/busy/b/done/err=%b bursts=%0d want 0000000 0",
               {m_axi_awvalid, m_axi_wvalid, s_axis_tready, busy, m_axi_bready, done, err}, bursts_done);
    end
    @(posedge clock);
    #1;
    idle(1);
    reset = 1'b0;
    flush = 1'b0;
    idle(2);
    aw0 = n_aw; w0 = n_w; s0 = stream_total;
    push_stream(64);
    exp_aw.push_back(64'h7000_0000);
    pulse_start(64'h7000_0000, 16'd1);
    wait_done(to);
    n_tests++;
    if (to !== 1'b0 || err !== 1'b0 || bursts_done !== 16'd1) begin
      n_fail++;
      $display("FAIL t6_new_job: timeout=%0d err=%0d bursts=%0d want 0 0 1", to, err, bursts_done);
    end
    @(posedge clock);
    #1;
    n_tests++;
    if (n_aw - aw0 !== 1) begin n_fail++; $display("FAIL t6_aw_count: got %0d want 1", n_aw - aw0); end
    for (int k = 0; exp_aw.size() > 0; k++) begin
      e = exp_aw.pop_front();
      n_tests++;
      if (obs_aw[aw0+k] !== e) begin
        n_fail++;
        $display("FAIL t6_awaddr: got %h want %h", obs_aw[aw0+k], e);
      end
    end
    bad = count_bad(w0, s0, 64);
    n_tests++;
    if (n_w - w0 !== 64 || bad !== 0) begin
      n_fail++;
      $display("FAIL t6_wdata: beats %0d bad %0d want 64 0", n_w - w0, bad);
    end
    n_tests++;
    if (attr_err !== 0 || proto_err !== 0) begin
      n_fail++;
      $display("FAIL t6_protocol: attr_err=%0d proto_err=%0d want 0 0", attr_err, proto_err);
    end
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_multi_burst_stalls();
    test_slverr();
    test_bad_cfg();
    test_start_while_busy();
    test_reset_mid_data();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
